// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshakes.
// Define CTRL_PERF_CNT_EN to add the instret/cycle_cnt performance counter outputs.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       ir_en,
  output logic       ab_en,
  output logic       alu_en,
  output logic       mdr_en,
  output logic       rf_we,
  output logic       busy,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] cycle_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for run at an instruction boundary
  // FETCH | imem_req held until imem_ready, IR loads
  // DECODE| A/B operands load, opcode checked
  // EXEC  | ALU result loads, branch/fence retire here
  // MEM   | dmem_req held until dmem_ready
  // WB    | register-file write and PC update
  // HALT  | illegal opcode or bus timeout, sticky until rst
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;

  logic is_load, is_store, is_branch, is_fence, is_jump, is_legal;
  logic waiting, to_hit;
  state_t boundary;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_fence  = (opcode == OP_FENCE);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_legal  = is_load || is_store || is_branch || is_fence || is_jump ||
                     (opcode == OP_OP) || (opcode == OP_IMM) ||
                     (opcode == OP_LUI) || (opcode == OP_AUIPC);

  assign boundary = run ? S_FETCH : S_IDLE;
  assign waiting  = ((state_q == S_FETCH) && !imem_ready) ||
                    ((state_q == S_MEM) && !dmem_ready);
  // The cycle in which the wait count reaches TIMEOUT; a ready in that cycle still wins.
  assign to_hit   = (TIMEOUT != 0) && waiting && (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    cnt_d     = cnt_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    ir_en     = 1'b0;
    ab_en     = 1'b0;
    alu_en    = 1'b0;
    mdr_en    = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_DECODE: begin
        ab_en = 1'b1;
        if (is_legal) state_d = S_EXEC;
        else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch || is_fence) begin
          pc_en   = 1'b1;
          pc_sel  = is_branch && br_taken;
          state_d = boundary;
        end else state_d = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_load) begin
            mdr_en  = 1'b1;
            state_d = S_WB;
          end else begin
            pc_en   = 1'b1;
            state_d = boundary;
          end
        end else if (to_hit) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_en   = 1'b1;
        pc_sel  = is_jump;
        state_d = boundary;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) cnt_d = 8'd0;
    else if (waiting) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state   = state_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret_q, instret_d, cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    instret_d   = instret_q + {31'd0, pc_en};
    cycle_cnt_d = cycle_cnt_q + {31'd0, busy};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q   <= 32'd0;
      cycle_cnt_q <= 32'd0;
    end else begin
      instret_q   <= instret_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign instret   = instret_q;
  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction timelines predicted from opcode and memory waits.
module tb_multicycle_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst, run;
  logic [6:0] opcode;
  logic       br_taken, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, pc_en, pc_sel, ir_en, ab_en, alu_en, mdr_en, rf_we;
  logic       busy, illegal, bus_err;
  logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret, cycle_cnt;
  int sum_pc = 0, sum_cyc = 0;
`endif

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_en(pc_en), .pc_sel(pc_sel),
    .ir_en(ir_en), .ab_en(ab_en), .alu_en(alu_en), .mdr_en(mdr_en), .rf_we(rf_we),
    .busy(busy), .illegal(illegal), .bus_err(bus_err), .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .instret(instret), .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    int         iw;
    int         dw;
    logic       br;
    logic       last;
  } plan_t;

  typedef struct {
    int cycles, ir_at, ab_at, alu_at, mdr_at, rf_at, pc_at, n_en, pc_sel;
    int n_ireq, n_dreq, n_we, n_busy, end_st, ill, berr;
  } rec_t;

  logic [6:0] legal_ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                                 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0001111};

  plan_t plan_q[$];
  rec_t  exp_q[$];
  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Timeline of one instruction from its first FETCH cycle (cycle 1), derived from the step rules.
  function automatic rec_t model(input plan_t p);
    rec_t r;
    bit ld, sto, bra, fen, jmp, ok;
    int t;
    r = '{default: 0};
    ld  = (p.op == 7'b0000011);
    sto = (p.op == 7'b0100011);
    bra = (p.op == 7'b1100011);
    fen = (p.op == 7'b0001111);
    jmp = (p.op == 7'b1101111) || (p.op == 7'b1100111);
    ok = 0;
    foreach (legal_ops[k]) if (legal_ops[k] == p.op) ok = 1;
    r.end_st = p.last ? 0 : 1;
    if (p.iw >= TO) begin
      r.cycles = TO; r.n_ireq = TO; r.end_st = 6; r.berr = 1;
    end else begin
      r.n_ireq = p.iw + 1; r.ir_at = p.iw + 1; r.ab_at = p.iw + 2; r.n_en = 2;
      t = p.iw + 2;
      if (!ok) begin
        r.end_st = 6; r.ill = 1;
      end else begin
        t++; r.alu_at = t;
        if (ld || sto) begin
          if (p.dw >= TO) begin
            r.n_dreq = TO; r.n_we = sto ? TO : 0; t += TO; r.end_st = 6; r.berr = 1;
          end else begin
            r.n_dreq = p.dw + 1; r.n_we = sto ? p.dw + 1 : 0; t += p.dw + 1;
            if (ld) begin r.mdr_at = t; t++; r.rf_at = t; end
            r.pc_at = t;
          end
        end else if (bra || fen) begin
          r.pc_at = t; r.pc_sel = bra ? int'(p.br) : 0;
        end else begin
          t++; r.rf_at = t; r.pc_at = t; r.pc_sel = int'(jmp);
        end
        r.n_en = 3 + int'(r.mdr_at != 0) + int'(r.rf_at != 0) + int'(r.pc_at != 0);
      end
      r.cycles = t;
    end
    r.n_busy = r.cycles;
    return r;
  endfunction

  task automatic issue(input logic [6:0] op, input int iw, input int dw, input logic br, input logic last);
    plan_t p;
    rec_t  r;
    p = '{op: op, iw: iw, dw: dw, br: br, last: last};
    r = model(p);
    plan_q.push_back(p);
    exp_q.push_back(r);
`ifdef CTRL_PERF_CNT_EN
    sum_pc += int'(r.pc_at != 0);
    sum_cyc += r.cycles;
`endif
  endtask

  // Memory/operand driver: answers reqs after the planned number of wait cycles.
  plan_t cur;
  int    iw_cnt = 0, dw_cnt = 0;
  initial begin
    imem_ready = 0; dmem_ready = 0; opcode = 7'd0; br_taken = 0;
    cur = '{op: 7'd0, iw: 0, dw: 0, br: 1'b0, last: 1'b0};
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        iw_cnt = 0; dw_cnt = 0; imem_ready = 0; dmem_ready = 0;
        continue;
      end
      if (imem_req) begin
        if (iw_cnt == 0) begin
          if (plan_q.size() == 0) begin
            total++; bad++;
            $display("FAIL plan_underflow: got fetch with no planned instruction");
            cur = '{op: 7'd0, iw: 0, dw: 0, br: 1'b0, last: 1'b1};
          end else cur = plan_q.pop_front();
          opcode = cur.op;
          br_taken = cur.br;
        end
        imem_ready = (iw_cnt == cur.iw);
        iw_cnt++;
      end else begin
        imem_ready = 0; iw_cnt = 0;
      end
      if (dmem_req) begin
        dmem_ready = (dw_cnt == cur.dw);
        dw_cnt++;
      end else begin
        dmem_ready = 0; dw_cnt = 0;
      end
      if (state == 3'd3 && cur.last) run = 0;
    end
  end

  // Monitor: rebuilds each instruction's observed timeline and checks it against the queue.
  rec_t act;
  bit   open_r = 0;
  int   st, prev_st = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        open_r = 0; prev_st = 0;
        continue;
      end
      st = int'(state);
      if (open_r && (st == 0 || st == 6 || (st == 1 && prev_st != 1))) begin
        rec_t e;
        act.end_st = st; act.ill = int'(illegal); act.berr = int'(bus_err);
        open_r = 0;
        if (exp_q.size() == 0) chk("unexpected_instr", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("cycles", act.cycles, e.cycles);
          chk("ir_at", act.ir_at, e.ir_at);
          chk("ab_at", act.ab_at, e.ab_at);
          chk("alu_at", act.alu_at, e.alu_at);
          chk("mdr_at", act.mdr_at, e.mdr_at);
          chk("rf_at", act.rf_at, e.rf_at);
          chk("pc_at", act.pc_at, e.pc_at);
          chk("enable_pulses", act.n_en, e.n_en);
          chk("pc_sel", act.pc_sel, e.pc_sel);
          chk("imem_req_cycles", act.n_ireq, e.n_ireq);
          chk("dmem_req_cycles", act.n_dreq, e.n_dreq);
          chk("dmem_we_cycles", act.n_we, e.n_we);
          chk("busy_cycles", act.n_busy, e.n_busy);
          chk("end_state", act.end_st, e.end_st);
          chk("illegal", act.ill, e.ill);
          chk("bus_err", act.berr, e.berr);
        end
      end
      if (st == 1 && prev_st != 1) begin
        act = '{default: 0};
        open_r = 1;
      end
      if (open_r) begin
        act.cycles++;
        if (ir_en  && act.ir_at  == 0) act.ir_at  = act.cycles;
        if (ab_en  && act.ab_at  == 0) act.ab_at  = act.cycles;
        if (alu_en && act.alu_at == 0) act.alu_at = act.cycles;
        if (mdr_en && act.mdr_at == 0) act.mdr_at = act.cycles;
        if (rf_we  && act.rf_at  == 0) act.rf_at  = act.cycles;
        if (pc_en  && act.pc_at  == 0) begin act.pc_at = act.cycles; act.pc_sel = int'(pc_sel); end
        act.n_en   += int'(ir_en) + int'(ab_en) + int'(alu_en) + int'(mdr_en) + int'(rf_we) + int'(pc_en);
        act.n_ireq += int'(imem_req);
        act.n_dreq += int'(dmem_req);
        act.n_we   += int'(dmem_req && dmem_we);
        act.n_busy += int'(busy);
      end
      if (st == 6)
        chk("halt_quiet", int'({imem_req, dmem_req, dmem_we, pc_en, pc_sel, ir_en, ab_en,
                                alu_en, mdr_en, rf_we, busy}), 0);
      prev_st = st;
    end
  end

  task automatic do_reset();
    run = 0;
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic drain(input string name, input int want_st);
    int k = 0;
    while ((exp_q.size() != 0 || int'(state) != want_st) && k < 2000) begin
      @(negedge clk); k++;
    end
    chk(name, int'(exp_q.size() == 0 && int'(state) == want_st), 1);
  endtask

  initial begin
    rst = 1; run = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_outputs", int'({imem_req, dmem_req, dmem_we, pc_en, pc_sel, ir_en, ab_en,
                             alu_en, mdr_en, rf_we, busy, illegal, bus_err}), 0);
    rst = 0;
    @(negedge clk);

    // Directed openers, then a randomized instruction stream; last one drops run.
    issue(7'b0110011, 0, 0, 1'b0, 1'b0);
    issue(7'b0000011, 0, 3, 1'b0, 1'b0);
    issue(7'b1100011, 0, 0, 1'b1, 1'b0);
    issue(7'b1100011, 1, 0, 1'b0, 1'b0);
    issue(7'b0100011, 3, 3, 1'b0, 1'b0);
    issue(7'b1101111, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++)
      issue(legal_ops[$urandom_range(0, 9)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'(i == 39));
    run = 1;
    drain("drain_random", 0);
`ifdef CTRL_PERF_CNT_EN
    chk("instret_random", int'(instret), sum_pc);
    chk("cycle_cnt_random", int'(cycle_cnt), sum_cyc);
`endif

    // Unsupported opcode halts after DECODE.
    do_reset();
    issue(7'b1110011, int'($urandom_range(0, 3)), 0, 1'b0, 1'b0);
    run = 1;
    drain("drain_illegal", 6);
    repeat (8) @(negedge clk);
    chk("illegal_sticky", int'(illegal), 1);
    chk("illegal_state", int'(state), 6);
    do_reset();
    chk("post_rst_state", int'(state), 0);
    chk("post_rst_illegal", int'(illegal), 0);

    // Fetch timeout, then a fetch answered on the last allowed wait cycle.
    issue(7'b0110011, 99, 0, 1'b0, 1'b0);
    run = 1;
    drain("drain_imem_to", 6);
    repeat (4) @(negedge clk);
    chk("imem_to_bus_err", int'(bus_err), 1);
    do_reset();
    chk("post_rst_bus_err", int'(bus_err), 0);
    issue(7'b0010011, TO - 1, 0, 1'b0, 1'b1);
    run = 1;
    drain("drain_imem_edge", 0);
    chk("imem_edge_no_err", int'(bus_err), 0);

    // Data-side timeouts for a load and a store.
    do_reset();
    issue(7'b0000011, 0, 99, 1'b0, 1'b0);
    run = 1;
    drain("drain_dmem_to_ld", 6);
    chk("dmem_to_ld_bus_err", int'(bus_err), 1);
    do_reset();
    issue(7'b0100011, 2, 99, 1'b0, 1'b0);
    run = 1;
    drain("drain_dmem_to_st", 6);
    chk("dmem_to_st_bus_err", int'(bus_err), 1);

    // Reset mid-fetch drops the request immediately.
    do_reset();
    plan_q.push_back('{op: 7'b0110011, iw: 2, dw: 0, br: 1'b0, last: 1'b1});
    run = 1;
    for (int k = 0; k < 20 && !imem_req; k++) @(negedge clk);
    chk("mid_fetch_req", int'(imem_req), 1);
    #2 rst = 1;
    #1;
    chk("async_req_drop", int'({imem_req, dmem_req, ir_en, pc_en, busy}), 0);
    chk("async_state", int'(state), 0);
    run = 0;
    @(negedge clk); rst = 0;
    chk("plan_consumed", plan_q.size(), 0);

    // Store with run dropped in EXEC completes, then idles.
    do_reset();
    issue(7'b0100011, 0, 0, 1'b0, 1'b1);
    run = 1;
    drain("drain_store_stop", 0);
`ifdef CTRL_PERF_CNT_EN
    chk("instret_store", int'(instret), 1);
    chk("cycle_cnt_store", int'(cycle_cnt), 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog");
  end
endmodule
